mix_columns_engine: RTL and testbench
=====================================

Name: mix_columns_engine

Overview:
- Iterative AES MixColumns / InvMixColumns unit for the round datapath, selectable per block via a mode input.
- Accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Holds the result until the consumer accepts it.
- Supports a bypass for the final round, where MixColumns is skipped.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4; NPASS = 4/COLS_PER_CYCLE.
- OUT_REG, 1, 1 = registered output path (out_data from a dedicated register); 0 = out_data driven from the working register.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream state valid
- in_ready  output  1  engine can accept a state
- in_data  input  128  state; column c = bits [127-32c -: 32], row 0 in the MSB byte of each column
- in_inv  input  1  1 = InvMixColumns (0e,0b,0d,09 matrix); 0 = MixColumns (02,03,01,01 matrix)
- in_bypass  input  1  1 = pass state through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  128  transformed state
- busy  output  1  high in BUSY state

Behaviour:
- Reset, synchronous on rst=1: state=IDLE, pass counter=0, out_valid=0, out_data=0, busy=0, working register=0. rst wins over every other input, including mid-operation; any in-flight block is discarded with no output.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture in_data, in_inv and in_bypass; clear the pass counter.
  - Go to DONE if in_bypass=1, otherwise to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - Each cycle, transform columns [cnt*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1] in place using the latched mode, then increment cnt.
  - After pass NPASS-1, go to DONE.
  - Mode and bypass are latched; in_inv/in_bypass changes during BUSY are ignored.
- DONE:
  - out_valid=1; out_data is stable until the handshake (out_valid & out_ready).
  - On handshake with in_valid=0: go to IDLE.
  - On handshake with in_valid=1: in_ready=1 in the same cycle, the new block is captured, and the state goes straight to BUSY (or stays in DONE for bypass). This gives back-to-back throughput with no bubble.
  - Without out_ready: hold; in_ready=0.
- Latency, capture edge to out_valid: NPASS+1 cycles for non-bypass (5/3/2 cycles for COLS_PER_CYCLE 4→... respectively 1/2/4 give 5/3/2); 1 cycle for bypass.
- Throughput with out_ready tied high: one block per NPASS+1 cycles.
- in_ready = (state==IDLE) | (state==DONE & out_ready); combinational from out_ready.
- Arithmetic:
  - GF(2^8) with polynomial 0x11B; xtime(b) = {b[6:0],0} ^ (b[7] ? 0x1B : 0).
  - Inverse coefficients are built from xtime chains: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
  - All byte math is 8-bit; no widening.
- Handshake rules: the upstream side must hold in_data/in_inv/in_bypass stable while in_valid=1 and in_ready=0. out_valid never drops without a handshake or rst.

Decomposition:
- aes_pkg holds the following, shared with the S-box and key-schedule blocks:
  - localparams GF_POLY=8'h1B and AES_NCOLS=4
  - function xtime
  - state_e enum (IDLE/BUSY/DONE)
- Sub-module mix_column_word: combinational, 32-bit column in, inv select, 32-bit column out. Instantiate it COLS_PER_CYCLE times; a generate loop selects the column slice by pass counter.

Test Plan:
- Forward, COLS_PER_CYCLE=1: in_data=db135345_f20a225c_01010101_c6c6c6c6, in_inv=0 → out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 5 cycles after capture.
- Inverse, COLS_PER_CYCLE=4: in_data=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, in_inv=1 → db135345_f20a225c_d4d4d4d5_2d26314c, out_valid 2 cycles after capture.
- Bypass: in_bypass=1, in_data=00112233_44556677_8899aabb_ccddeeff → identical out_data, 1 cycle later.
- Backpressure plus back-to-back, with out_ready held 0 for 3 cycles:
  - out_data is stable and in_ready=0 while out_ready=0.
  - Raise out_ready with in_valid=1 → handshake and new capture in the same cycle.
  - Second result is correct; no bubble.
- Reset mid-BUSY: assert rst during pass 1 → the next cycle shows state IDLE, out_valid=0, out_data=0, in_ready=1. Then a fresh block completes correctly.
- Random regression over all three COLS_PER_CYCLE values: 1000 random states, forward then inverse → round-trip equals the original; results match a reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) constants, the xtime helper and the
// engine FSM state type, used by the MixColumns, S-box and key-schedule blocks.
// No ports; purely declarations.
package aes_pkg;

    // Reduction term for x^8 under the AES polynomial x^8+x^4+x^3+x+1 (0x11B)
    localparam logic [7:0] GF_POLY   = 8'h1B;
    localparam int         AES_NCOLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Multiply by x in GF(2^8), staying in 8 bits
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// One AES column through MixColumns (inv=0) or InvMixColumns (inv=1).
// Latency: combinational, zero cycles. Backpressure: none, pure function.
// Ports: column (32b, row 0 in MSB byte), inv (mode), mixed (32b result).
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] column,
    input  logic        inv,
    output logic [31:0] mixed
);

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    // Per-byte coefficient products, built from xtime chains
    logic [7:0] m1 [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] r  [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a[i]  = column[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m1[i] = a[i];
            m2[i] = x2[i];
            m3[i] = x2[i] ^ a[i];
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        // Row i uses the circulant matrix rotated right by i: the byte at
        // offset k from the diagonal gets coefficient k of the first row.
        for (int i = 0; i < 4; i++) begin
            if (inv) begin
                r[i] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
            end else begin
                r[i] = m2[i] ^ m3[(i+1)%4] ^ m1[(i+2)%4] ^ m1[(i+3)%4];
            end
        end
        mixed = {r[0], r[1], r[2], r[3]};
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns/InvMixColumns, COLS_PER_CYCLE columns per clock, with final-round bypass.
// Latency: capture to out_valid is NPASS+1 cycles (bypass: 1 cycle); one block per NPASS+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready follows out_ready in DONE for bubble-free reuse.
// Ports: clk, rst (sync, active high); in_valid/in_ready/in_data/in_inv/in_bypass upstream;
//        out_valid/out_ready/out_data downstream; busy while columns are being transformed.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter int OUT_REG        = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         NPASS     = AES_NCOLS / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_PASS = 2'(NPASS - 1);

    state_e       state_q, state_d;
    logic [1:0]   cnt_q;
    logic         inv_q;
    logic [127:0] work_q;
    logic [127:0] work_nxt;
    logic         capture;
    logic         step;
    logic         last_pass;

    logic [31:0]  cols_q  [AES_NCOLS];
    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  col_sel [COLS_PER_CYCLE];
    logic [31:0]  col_mix [COLS_PER_CYCLE];

    // Column view of the working register
    always_comb begin
        for (int c = 0; c < AES_NCOLS; c++) begin
            cols_q[c] = work_q[127-32*c -: 32];
        end
    end

    // Each lane works on column cnt*COLS_PER_CYCLE + lane this pass
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
        assign col_idx[g] = 2'((32'(cnt_q) * COLS_PER_CYCLE + g) % AES_NCOLS);
        assign col_sel[g] = cols_q[col_idx[g]];

        mix_column_word u_mcw (
            .column (col_sel[g]),
            .inv    (inv_q),
            .mixed  (col_mix[g])
        );
    end

    // Write the transformed lanes back in place, other columns untouched
    always_comb begin
        work_nxt = work_q;
        for (int c = 0; c < AES_NCOLS; c++) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                if (col_idx[g] == 2'(c)) begin
                    work_nxt[127-32*c -: 32] = col_mix[g];
                end
            end
        end
    end

    assign last_pass = (cnt_q == LAST_PASS);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_pass) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    // Reuse the handshake cycle to take the next block
                    if (in_valid) begin
                        state_d = in_bypass ? DONE : BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign capture = in_ready & in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            inv_q   <= 1'b0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                work_q <= in_data;
                inv_q  <= in_inv;
                cnt_q  <= 2'd0;
            end else if (step) begin
                work_q <= work_nxt;
                cnt_q  <= cnt_q + 2'd1;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [127:0] out_q;

        // Loaded on the edge that enters DONE, so it is valid with out_valid
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q <= '0;
            end else if (capture && in_bypass) begin
                out_q <= in_data;
            end else if (step && last_pass) begin
                out_q <= work_nxt;
            end
        end

        assign out_data = out_q;
    end else begin : g_out_work
        assign out_data = work_q;
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed-vector and random round-trip bench for mix_columns_engine across
// COLS_PER_CYCLE = 1, 2, 4 (instances 0, 1, 2).
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data   = '0;
    logic         in_inv    = 1'b0;
    logic         in_bypass = 1'b0;

    logic         in_valid  [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1), .OUT_REG(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    mix_columns_engine #(.COLS_PER_CYCLE(2), .OUT_REG(0)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    mix_columns_engine #(.COLS_PER_CYCLE(4), .OUT_REG(1)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data), .in_inv(in_inv), .in_bypass(in_bypass),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2])
    );

    typedef struct {
        int           cfg;
        logic [127:0] din;
        logic         inv;
        logic         byp;
        logic [127:0] dexp;
    } vec_t;

    vec_t tbl [9];

    function automatic int npass(input int cfg);
        return (cfg == 0) ? 4 : (cfg == 1) ? 2 : 1;
    endfunction

    // Reference: generic shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
        logic [127:0] r = '0;
        logic [7:0]   m [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - row + 4) % 4], a[j]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Send one block to instance k with out_ready high; returns result and
    // the number of negedges from the capture edge until out_valid.
    task automatic run_block(input int k, input logic [127:0] d, input logic inv,
                             input logic byp, output logic [127:0] res, output int lat);
        @(negedge clk);
        in_data      = d;
        in_inv       = inv;
        in_bypass    = byp;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 1;
        while (!out_valid[k] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid[k]) begin
            res = 'x;
            chk("timeout", 128'(lat), 128'(0));
        end else begin
            res = out_data[k];
        end
        @(posedge clk);
    endtask

    initial begin
        logic [127:0] res, res2, orig, a_exp, b_exp;
        int           lat, lat_exp;

        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end

        tbl[0] = '{0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
                      128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        tbl[1] = '{2, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, 1'b0,
                      128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
        tbl[2] = '{0, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1,
                      128'h00112233_44556677_8899aabb_ccddeeff};
        tbl[3] = '{1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
                      128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6};
        tbl[4] = '{0, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, 1'b0,
                      128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
        tbl[5] = '{1, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1, 1'b0,
                      128'hdb135345_f20a225c_d4d4d4d5_2d26314c};
        tbl[6] = '{2, 128'hd4d4d4d5_2d26314c_db135345_f20a225c, 1'b0, 1'b0,
                      128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d};
        tbl[7] = '{1, 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1,
                      128'h00112233_44556677_8899aabb_ccddeeff};
        tbl[8] = '{2, 128'h0, 1'b0, 1'b0, 128'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state of every instance
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", 128'(out_valid[k]), 128'(0));
            chk("rst_out_data",  out_data[k],        128'(0));
            chk("rst_in_ready",  128'(in_ready[k]),  128'(1));
            chk("rst_busy",      128'(busy[k]),      128'(0));
        end

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_block(tbl[i].cfg, tbl[i].din, tbl[i].inv, tbl[i].byp, res, lat);
            lat_exp = tbl[i].byp ? 1 : npass(tbl[i].cfg) + 1;
            chk($sformatf("vec%0d_data", i), res, tbl[i].dexp);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(lat_exp));
            @(negedge clk);
            chk($sformatf("vec%0d_idle_after", i), 128'(out_valid[tbl[i].cfg]), 128'(0));
        end

        // Backpressure then back-to-back on COLS_PER_CYCLE=1
        a_exp = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        b_exp = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
        @(negedge clk);
        in_data      = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        in_inv       = 1'b0;
        in_bypass    = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        lat = 1;
        while (!out_valid[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_first_latency", 128'(lat), 128'(5));
        in_data     = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
        in_inv      = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_data",  out_data[0],        a_exp);
            chk("bp_hold_valid", 128'(out_valid[0]), 128'(1));
            chk("bp_in_ready",   128'(in_ready[0]),  128'(0));
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        #1;
        chk("b2b_in_ready", 128'(in_ready[0]), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        // Mode changes while busy must be ignored
        in_inv      = 1'b0;
        in_bypass   = 1'b1;
        chk("b2b_no_bubble", 128'(busy[0]),      128'(1));
        chk("b2b_valid_low", 128'(out_valid[0]), 128'(0));
        lat = 1;
        while (!out_valid[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_latency", 128'(lat), 128'(5));
        chk("b2b_data", out_data[0], b_exp);
        @(posedge clk);
        in_bypass = 1'b0;

        // Reset during pass 1
        @(negedge clk);
        in_data     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        in_inv      = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy",      128'(busy[0]),      128'(0));
        chk("midrst_out_valid", 128'(out_valid[0]), 128'(0));
        chk("midrst_out_data",  out_data[0],        128'(0));
        chk("midrst_in_ready",  128'(in_ready[0]),  128'(1));
        run_block(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, res, lat);
        chk("midrst_fresh_data", res, a_exp);
        chk("midrst_fresh_latency", 128'(lat), 128'(5));

        // Random round trips on all three widths
        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 3; k++) begin
                run_block(k, orig, 1'b0, 1'b0, res, lat);
                chk($sformatf("rand%0d_c%0d_fwd", i, k), res, mix_model(orig, 1'b0));
                run_block(k, res, 1'b1, 1'b0, res2, lat);
                chk($sformatf("rand%0d_c%0d_roundtrip", i, k), res2, orig);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
